wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
- Shares one Wishbone slave port between NUM_MASTERS Wishbone masters, for example several BFM masters driving one slave model or DUT port.
- Arbitration is round-robin at bus-cycle granularity. A grant is held for the whole CYC assertion of the granted master, so bursts and locked sequences are never split.
- An optional watchdog terminates slave cycles that never respond, by returning ERR to the owning master.

Parameters:
- NUM_MASTERS, 2: number of requesting masters, 2..8.
- WB_ADDR_WIDTH, 32: address width.
- WB_DATA_WIDTH, 32: data width. SEL width is WB_DATA_WIDTH/8.
- TIMEOUT, 0: cycles of STB without ACK/ERR before forced ERR. 0 disables the watchdog.

Ports:
- clk  in  1  clock; all logic on posedge.
- rstn  in  1  asynchronous, active-low reset.
- m_CYC  in  NUM_MASTERS  per-master CYC; bit i is master i.
- m_STB  in  NUM_MASTERS  per-master STB.
- m_WE  in  NUM_MASTERS  per-master WE.
- m_ADR  in  NUM_MASTERS*WB_ADDR_WIDTH  packed addresses; slice i is master i.
- m_DAT_W  in  NUM_MASTERS*WB_DATA_WIDTH  packed write data.
- m_SEL  in  NUM_MASTERS*WB_DATA_WIDTH/8  packed byte selects.
- m_CTI  in  NUM_MASTERS*3  packed CTI.
- m_BTE  in  NUM_MASTERS*2  packed BTE.
- m_DAT_R  out  WB_DATA_WIDTH  read data, broadcast to all masters.
- m_ACK  out  NUM_MASTERS  per-master ACK.
- m_ERR  out  NUM_MASTERS  per-master ERR.
- s_CYC, s_STB, s_WE  out  1  to slave.
- s_ADR  out  WB_ADDR_WIDTH  to slave.
- s_DAT_W  out  WB_DATA_WIDTH  to slave.
- s_SEL  out  WB_DATA_WIDTH/8  to slave.
- s_CTI  out  3  to slave.
- s_BTE  out  2  to slave.
- s_DAT_R  in  WB_DATA_WIDTH  from slave.
- s_ACK, s_ERR  in  1  from slave.
- grant  out  NUM_MASTERS  one-hot current owner, all-zero when idle; for debug and coverage.

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=IDLE, grant=0, last=NUM_MASTERS-1 (so master 0 has first priority), watchdog counter=0.
  - All s_* outputs, m_ACK and m_ERR are 0 while grant=0.
- State IDLE:
  - If any m_CYC is 1 at a posedge, select the first requester scanning (last+1) mod N upward with wrap.
  - Registered effects at that edge: grant is set to the one-hot owner; last=owner; state=BUSY.
  - Grant latency is one cycle from CYC assertion.
- State BUSY, slave side:
  - s_CYC/s_STB/s_WE/s_ADR/s_DAT_W/s_SEL/s_CTI/s_BTE are combinationally muxed from the owner's slices.
- State BUSY, master side:
  - m_ACK[owner]=s_ACK and m_ERR[owner]=s_ERR; all non-owners see 0.
  - m_DAT_R=s_DAT_R for all masters (non-owners ignore it).
- Release:
  - When m_CYC[owner]=0 at a posedge: state=IDLE, grant=0.
  - The next arbitration happens in IDLE at the following edge, giving one mandatory dead cycle between owners.
  - Release is never triggered by ACK alone; the owner keeps the bus across consecutive STB beats while CYC stays high.
- Simultaneous requests: only the round-robin winner is granted. Losers keep CYC asserted and are served in rotation order.
- Watchdog (TIMEOUT>0):
  - Counter increments each BUSY cycle with s_STB=1 and s_ACK=0 and s_ERR=0. It clears on ACK/ERR, when s_STB=0, or in IDLE.
  - When counter==TIMEOUT-1 and still no response: on the next cycle, pulse m_ERR[owner]=1 for exactly one cycle.
  - That pulse is generated internally even though s_ERR=0. During the same cycle s_STB and s_CYC are forced to 0.
  - The counter then clears. State stays BUSY until the owner drops CYC.
  - Counter width is clog2(TIMEOUT+1).
- A slave ACK and ERR in the same cycle are both forwarded unchanged; the arbiter does not resolve them.
- A master dropping CYC mid-burst with STB still high: release proceeds at that edge; the slave sees CYC fall with it.
- Reset mid-transfer: outputs drop immediately and asynchronously; pending requests are re-arbitrated from master 0 after rstn rises.
- Out-of-range slices do not exist; NUM_MASTERS outside 2..8 is an elaboration error.

Test Plan:
- Single master: master 1 asserts CYC/STB with a write to ADR=0x100, DAT=0xDEADBEEF.
  - grant=2'b10 one cycle later; the slave sees identical ADR/DAT/SEL.
  - ACK is routed only to m_ACK[1]; grant=0 the cycle after CYC drops.
- Contention after reset: masters 0 and 1 assert CYC in the same cycle.
  - Master 0 is granted first. After it releases there is one idle cycle, then master 1 is granted.
  - A repeat contention then grants master 0 again (rotation verified).
- Burst hold: master 0 does a 4-beat CTI=3'b010 incrementing burst while master 1 requests.
  - All 4 ACKs go to master 0; grant never changes until master 0 drops CYC.
- Watchdog: TIMEOUT=8, slave never ACKs.
  - m_ERR[owner] pulses once, exactly 8 cycles after STB is first presented; s_STB=0 in that cycle.
  - Other masters see no ACK/ERR.
- Async reset: rstn is pulled low mid-burst between clock edges.
  - s_CYC/s_STB/grant go to 0 before the next posedge.
  - After rstn is released, masters 2 and 0 both requesting results in master 0 being granted.
- Slave ERR: slave returns s_ERR=1 on a read to master 2 (NUM_MASTERS=4).
  - m_ERR=4'b0100 and m_ACK=0.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS masters share one slave port.
// A grant is held for the owner's whole CYC assertion, with one dead cycle
// between owners. An optional watchdog turns a silent slave into an ERR.

// Per-master slice: masks the master's request with its grant bit and routes
// the slave response back only when this master owns the bus.
module wb_rr_lane #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            gnt,
    input  logic            cyc,
    input  logic            stb,
    input  logic            we,
    input  logic [AW-1:0]   adr,
    input  logic [DW-1:0]   dat,
    input  logic [DW/8-1:0] sel,
    input  logic [2:0]      cti,
    input  logic [1:0]      bte,
    input  logic            s_ack,
    input  logic            s_err,
    input  logic            wd_err,
    output logic            o_cyc,
    output logic            o_stb,
    output logic            o_we,
    output logic [AW-1:0]   o_adr,
    output logic [DW-1:0]   o_dat,
    output logic [DW/8-1:0] o_sel,
    output logic [2:0]      o_cti,
    output logic [1:0]      o_bte,
    output logic            m_ack,
    output logic            m_err
);
    assign o_cyc = gnt & cyc;
    assign o_stb = gnt & stb;
    assign o_we  = gnt & we;
    assign o_adr = gnt ? adr : '0;
    assign o_dat = gnt ? dat : '0;
    assign o_sel = gnt ? sel : '0;
    assign o_cti = gnt ? cti : '0;
    assign o_bte = gnt ? bte : '0;
    // ACK and ERR pass through unresolved; watchdog ERR is OR'd in.
    assign m_ack = gnt & s_ack;
    assign m_err = gnt & (s_err | wd_err);
endmodule

module wb_rr_arbiter #(
    parameter int NUM_MASTERS   = 2,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32,
    parameter int TIMEOUT       = 0
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic [NUM_MASTERS-1:0]                 m_CYC,
    input  logic [NUM_MASTERS-1:0]                 m_STB,
    input  logic [NUM_MASTERS-1:0]                 m_WE,
    input  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0]   m_ADR,
    input  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0]   m_DAT_W,
    input  logic [NUM_MASTERS*WB_DATA_WIDTH/8-1:0] m_SEL,
    input  logic [NUM_MASTERS*3-1:0]               m_CTI,
    input  logic [NUM_MASTERS*2-1:0]               m_BTE,
    output logic [WB_DATA_WIDTH-1:0]               m_DAT_R,
    output logic [NUM_MASTERS-1:0]                 m_ACK,
    output logic [NUM_MASTERS-1:0]                 m_ERR,
    output logic                                   s_CYC,
    output logic                                   s_STB,
    output logic                                   s_WE,
    output logic [WB_ADDR_WIDTH-1:0]               s_ADR,
    output logic [WB_DATA_WIDTH-1:0]               s_DAT_W,
    output logic [WB_DATA_WIDTH/8-1:0]             s_SEL,
    output logic [2:0]                             s_CTI,
    output logic [1:0]                             s_BTE,
    input  logic [WB_DATA_WIDTH-1:0]               s_DAT_R,
    input  logic                                   s_ACK,
    input  logic                                   s_ERR,
    output logic [NUM_MASTERS-1:0]                 grant
);
    localparam int N  = NUM_MASTERS;
    localparam int AW = WB_ADDR_WIDTH;
    localparam int DW = WB_DATA_WIDTH;
    localparam int SW = WB_DATA_WIDTH / 8;
    localparam int LW = $clog2(NUM_MASTERS);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    if ((NUM_MASTERS < 2) || (NUM_MASTERS > 8)) begin : g_bad_n
        $error("wb_rr_arbiter: NUM_MASTERS must be 2..8");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [LW-1:0]   last_q, last_d;
    logic [CW-1:0]   wd_cnt_q, wd_cnt_d;
    logic            wd_err_q, wd_err_d;

    logic [N-1:0]          l_cyc, l_stb, l_we;
    logic [N-1:0][AW-1:0]  l_adr;
    logic [N-1:0][DW-1:0]  l_dat;
    logic [N-1:0][SW-1:0]  l_sel;
    logic [N-1:0][2:0]     l_cti;
    logic [N-1:0][1:0]     l_bte;
    logic                  owner_cyc;
    logic                  found;
    int                    idx;

    for (genvar i = 0; i < N; i++) begin : g_lane
        wb_rr_lane #(.AW(AW), .DW(DW)) u_lane (
            .gnt    (grant_q[i]),
            .cyc    (m_CYC[i]),
            .stb    (m_STB[i]),
            .we     (m_WE[i]),
            .adr    (m_ADR[i*AW +: AW]),
            .dat    (m_DAT_W[i*DW +: DW]),
            .sel    (m_SEL[i*SW +: SW]),
            .cti    (m_CTI[i*3 +: 3]),
            .bte    (m_BTE[i*2 +: 2]),
            .s_ack  (s_ACK),
            .s_err  (s_ERR),
            .wd_err (wd_err_q),
            .o_cyc  (l_cyc[i]),
            .o_stb  (l_stb[i]),
            .o_we   (l_we[i]),
            .o_adr  (l_adr[i]),
            .o_dat  (l_dat[i]),
            .o_sel  (l_sel[i]),
            .o_cti  (l_cti[i]),
            .o_bte  (l_bte[i]),
            .m_ack  (m_ACK[i]),
            .m_err  (m_ERR[i])
        );
    end

    // AND-OR mux of the masked lanes; all-zero when nobody holds the bus.
    // The watchdog pulse cycle withdraws CYC/STB from the slave.
    always_comb begin
        s_CYC   = 1'b0;
        s_STB   = 1'b0;
        s_WE    = 1'b0;
        s_ADR   = '0;
        s_DAT_W = '0;
        s_SEL   = '0;
        s_CTI   = '0;
        s_BTE   = '0;
        for (int i = 0; i < N; i++) begin
            s_CYC   = s_CYC   | l_cyc[i];
            s_STB   = s_STB   | l_stb[i];
            s_WE    = s_WE    | l_we[i];
            s_ADR   = s_ADR   | l_adr[i];
            s_DAT_W = s_DAT_W | l_dat[i];
            s_SEL   = s_SEL   | l_sel[i];
            s_CTI   = s_CTI   | l_cti[i];
            s_BTE   = s_BTE   | l_bte[i];
        end
        s_CYC = s_CYC & ~wd_err_q;
        s_STB = s_STB & ~wd_err_q;
    end

    assign m_DAT_R   = s_DAT_R;
    assign grant     = grant_q;
    assign owner_cyc = |(m_CYC & grant_q);

    // Next state: rotating-priority pick in IDLE, hold/release and watchdog in BUSY.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        wd_cnt_d = '0;
        wd_err_d = 1'b0;
        found    = 1'b0;
        idx      = 0;
        case (state_q)
            IDLE: begin
                if (|m_CYC) begin
                    for (int i = 1; i <= N; i++) begin
                        idx = int'(last_q) + i;
                        if (idx >= N) idx = idx - N;
                        if (!found && m_CYC[idx]) begin
                            found   = 1'b1;
                            grant_d = N'(1) << idx;
                            last_d  = LW'(idx);
                        end
                    end
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!owner_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if ((TIMEOUT > 0) && s_STB && !s_ACK && !s_ERR) begin
                    if (wd_cnt_q == CW'(TIMEOUT - 1)) wd_err_d = 1'b1;
                    else                              wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers; reset leaves master 0 with first priority.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            last_q   <= LW'(N - 1);
            wd_cnt_q <= '0;
            wd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            wd_cnt_q <= wd_cnt_d;
            wd_err_q <= wd_err_d;
        end
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter with 4 masters and an 8-cycle watchdog.
module tb_wb_rr_arbiter;
    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic                clk = 1'b0;
    logic                rstn;
    logic [NM-1:0]       m_CYC, m_STB, m_WE;
    logic [NM*AW-1:0]    m_ADR;
    logic [NM*DW-1:0]    m_DAT_W;
    logic [NM*SW-1:0]    m_SEL;
    logic [NM*3-1:0]     m_CTI;
    logic [NM*2-1:0]     m_BTE;
    logic [DW-1:0]       m_DAT_R;
    logic [NM-1:0]       m_ACK, m_ERR, grant;
    logic                s_CYC, s_STB, s_WE;
    logic [AW-1:0]       s_ADR;
    logic [DW-1:0]       s_DAT_W;
    logic [SW-1:0]       s_SEL;
    logic [2:0]          s_CTI;
    logic [1:0]          s_BTE;
    logic [DW-1:0]       s_DAT_R;
    logic                s_ACK, s_ERR;

    int checks = 0;
    int errors = 0;

    wb_rr_arbiter #(.NUM_MASTERS(NM), .WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW), .TIMEOUT(8)) dut (
        .clk(clk), .rstn(rstn),
        .m_CYC(m_CYC), .m_STB(m_STB), .m_WE(m_WE), .m_ADR(m_ADR), .m_DAT_W(m_DAT_W),
        .m_SEL(m_SEL), .m_CTI(m_CTI), .m_BTE(m_BTE), .m_DAT_R(m_DAT_R),
        .m_ACK(m_ACK), .m_ERR(m_ERR),
        .s_CYC(s_CYC), .s_STB(s_STB), .s_WE(s_WE), .s_ADR(s_ADR), .s_DAT_W(s_DAT_W),
        .s_SEL(s_SEL), .s_CTI(s_CTI), .s_BTE(s_BTE), .s_DAT_R(s_DAT_R),
        .s_ACK(s_ACK), .s_ERR(s_ERR), .grant(grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cyc, stb;
        logic        sack, serr;
        logic [3:0]  g, ack, err;
        logic        scyc, sstb;
        logic [31:0] sadr;
        logic [2:0]  cti;
    } vec_t;

    vec_t tv[$];

    // Per-master constant request fields, also used to build expectations.
    logic [AW-1:0] adr_c [NM];
    logic [DW-1:0] dat_c [NM];
    logic [SW-1:0] sel_c [NM];
    logic          we_c  [NM];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] cyc, input logic [3:0] stb, input logic sack,
                       input logic serr, input logic [3:0] g, input logic [3:0] ack,
                       input logic [3:0] err, input logic scyc, input logic sstb,
                       input logic [31:0] sadr, input logic [2:0] cti);
        vec_t v;
        v.cyc = cyc; v.stb = stb; v.sack = sack; v.serr = serr;
        v.g = g; v.ack = ack; v.err = err; v.scyc = scyc; v.sstb = sstb;
        v.sadr = sadr; v.cti = cti;
        tv.push_back(v);
    endtask

    task automatic drive(input logic [3:0] cyc, input logic [3:0] stb, input logic sack,
                         input logic serr);
        m_CYC = cyc; m_STB = stb; s_ACK = sack; s_ERR = serr;
    endtask

    initial begin
        logic [DW-1:0] e_dat;
        logic [SW-1:0] e_sel;
        logic          e_we;

        for (int i = 0; i < NM; i++) begin
            adr_c[i] = 32'h100 * i;
            dat_c[i] = (i == 1) ? 32'hDEADBEEF : 32'h11111111 * i;
            sel_c[i] = (i == 1) ? 4'hF : 4'h3;
            we_c[i]  = (i == 1);
            m_ADR[i*AW +: AW]   = adr_c[i];
            m_DAT_W[i*DW +: DW] = dat_c[i];
            m_SEL[i*SW +: SW]   = sel_c[i];
            m_WE[i]             = we_c[i];
            m_CTI[i*3 +: 3]     = (i == 0) ? 3'b010 : 3'b000;
            m_BTE[i*2 +: 2]     = 2'b00;
        end
        s_DAT_R = 32'hCAFE0000;

        //   cyc      stb      ack  err   grant    m_ack    m_err    scyc sstb sadr    cti
        // single master 1
        add(4'b0010, 4'b0010, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h000, 3'b000);
        add(4'b0010, 4'b0010, 1, 0, 4'b0010, 4'b0010, 4'b0000, 1, 1, 32'h100, 3'b000);
        add(4'b0000, 4'b0000, 0, 0, 4'b0010, 4'b0000, 4'b0000, 0, 0, 32'h100, 3'b000);
        add(4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h000, 3'b000);
        // contention 0/1, dead cycle, then rotation back to 0
        add(4'b0011, 4'b0011, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h000, 3'b000);
        add(4'b0011, 4'b0011, 1, 0, 4'b0001, 4'b0001, 4'b0000, 1, 1, 32'h000, 3'b010);
        add(4'b0010, 4'b0010, 0, 0, 4'b0001, 4'b0000, 4'b0000, 0, 0, 32'h000, 3'b010);
        add(4'b0010, 4'b0010, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h000, 3'b000);
        add(4'b0010, 4'b0010, 1, 0, 4'b0010, 4'b0010, 4'b0000, 1, 1, 32'h100, 3'b000);
        add(4'b0001, 4'b0001, 0, 0, 4'b0010, 4'b0000, 4'b0000, 0, 0, 32'h100, 3'b000);
        add(4'b0011, 4'b0011, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h000, 3'b000);
        add(4'b0011, 4'b0011, 1, 0, 4'b0001, 4'b0001, 4'b0000, 1, 1, 32'h000, 3'b010);
        add(4'b0000, 4'b0000, 0, 0, 4'b0001, 4'b0000, 4'b0000, 0, 0, 32'h000, 3'b010);
        add(4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h000, 3'b000);
        // 4-beat burst by master 0 with master 1 waiting
        add(4'b0001, 4'b0001, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h000, 3'b000);
        add(4'b0011, 4'b0011, 1, 0, 4'b0001, 4'b0001, 4'b0000, 1, 1, 32'h000, 3'b010);
        add(4'b0011, 4'b0011, 0, 0, 4'b0001, 4'b0000, 4'b0000, 1, 1, 32'h000, 3'b010);
        add(4'b0011, 4'b0011, 1, 0, 4'b0001, 4'b0001, 4'b0000, 1, 1, 32'h000, 3'b010);
        add(4'b0011, 4'b0011, 1, 0, 4'b0001, 4'b0001, 4'b0000, 1, 1, 32'h000, 3'b010);
        add(4'b0011, 4'b0011, 1, 0, 4'b0001, 4'b0001, 4'b0000, 1, 1, 32'h000, 3'b010);
        add(4'b0010, 4'b0010, 0, 0, 4'b0001, 4'b0000, 4'b0000, 0, 0, 32'h000, 3'b010);
        add(4'b0010, 4'b0010, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h000, 3'b000);
        add(4'b0010, 4'b0010, 1, 0, 4'b0010, 4'b0010, 4'b0000, 1, 1, 32'h100, 3'b000);
        add(4'b0000, 4'b0000, 0, 0, 4'b0010, 4'b0000, 4'b0000, 0, 0, 32'h100, 3'b000);
        add(4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h000, 3'b000);
        // slave ERR to master 2, then ACK+ERR together to master 3
        add(4'b0100, 4'b0100, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h000, 3'b000);
        add(4'b0100, 4'b0100, 0, 1, 4'b0100, 4'b0000, 4'b0100, 1, 1, 32'h200, 3'b000);
        add(4'b0000, 4'b0000, 0, 0, 4'b0100, 4'b0000, 4'b0000, 0, 0, 32'h200, 3'b000);
        add(4'b1000, 4'b1000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h000, 3'b000);
        add(4'b1000, 4'b1000, 1, 1, 4'b1000, 4'b1000, 4'b1000, 1, 1, 32'h300, 3'b000);
        add(4'b0000, 4'b0000, 0, 0, 4'b1000, 4'b0000, 4'b0000, 0, 0, 32'h300, 3'b000);
        add(4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h000, 3'b000);

        // Reset with everyone requesting: nothing may leak out.
        rstn = 1'b0;
        drive(4'b1111, 4'b1111, 1, 1);
        #12;
        chk("rst grant", 64'(grant), 64'(0));
        chk("rst s_CYC", 64'(s_CYC), 64'(0));
        chk("rst s_STB", 64'(s_STB), 64'(0));
        chk("rst m_ACK", 64'(m_ACK), 64'(0));
        chk("rst m_ERR", 64'(m_ERR), 64'(0));
        drive(4'b0000, 4'b0000, 0, 0);
        @(negedge clk);
        rstn = 1'b1;

        foreach (tv[k]) begin
            drive(tv[k].cyc, tv[k].stb, tv[k].sack, tv[k].serr);
            s_DAT_R = 32'hCAFE0000 + 32'(k);
            #1;
            e_dat = '0; e_sel = '0; e_we = 1'b0;
            for (int i = 0; i < NM; i++)
                if (tv[k].g[i]) begin
                    e_dat = dat_c[i]; e_sel = sel_c[i]; e_we = we_c[i];
                end
            chk($sformatf("v%0d grant", k), 64'(grant), 64'(tv[k].g));
            chk($sformatf("v%0d m_ACK", k), 64'(m_ACK), 64'(tv[k].ack));
            chk($sformatf("v%0d m_ERR", k), 64'(m_ERR), 64'(tv[k].err));
            chk($sformatf("v%0d s_CYC", k), 64'(s_CYC), 64'(tv[k].scyc));
            chk($sformatf("v%0d s_STB", k), 64'(s_STB), 64'(tv[k].sstb));
            chk($sformatf("v%0d s_ADR", k), 64'(s_ADR), 64'(tv[k].sadr));
            chk($sformatf("v%0d s_CTI", k), 64'(s_CTI), 64'(tv[k].cti));
            chk($sformatf("v%0d s_DAT_W", k), 64'(s_DAT_W), 64'(e_dat));
            chk($sformatf("v%0d s_SEL", k), 64'(s_SEL), 64'(e_sel));
            chk($sformatf("v%0d s_WE", k), 64'(s_WE), 64'(e_we));
            chk($sformatf("v%0d m_DAT_R", k), 64'(m_DAT_R), 64'(32'hCAFE0000 + 32'(k)));
            @(negedge clk);
        end

        // Watchdog: master 1 wins over master 2, slave stays silent.
        drive(4'b0110, 4'b0110, 0, 0);
        #1 chk("wd pre grant", 64'(grant), 64'(0));
        @(negedge clk);
        for (int c = 0; c <= 10; c++) begin
            #1;
            chk($sformatf("wd c%0d grant", c), 64'(grant), 64'(4'b0010));
            chk($sformatf("wd c%0d m_ERR", c), 64'(m_ERR), (c == 8) ? 64'(4'b0010) : 64'(0));
            chk($sformatf("wd c%0d m_ACK", c), 64'(m_ACK), 64'(0));
            chk($sformatf("wd c%0d s_STB", c), 64'(s_STB), (c == 8) ? 64'(0) : 64'(1));
            chk($sformatf("wd c%0d s_CYC", c), 64'(s_CYC), (c == 8) ? 64'(0) : 64'(1));
            @(negedge clk);
        end
        drive(4'b0100, 4'b0100, 0, 0);
        @(negedge clk);
        #1 chk("wd release grant", 64'(grant), 64'(0));
        @(negedge clk);
        #1 chk("wd next owner", 64'(grant), 64'(4'b0100));
        drive(4'b0000, 4'b0000, 0, 0);
        @(negedge clk);
        @(negedge clk);

        // Async reset mid-burst by master 0, then 2 and 0 contend.
        drive(4'b0001, 4'b0001, 0, 0);
        @(negedge clk);
        #1 chk("ar owner", 64'(grant), 64'(4'b0001));
        chk("ar s_CYC high", 64'(s_CYC), 64'(1));
        #1 rstn = 1'b0;
        #1;
        chk("ar grant", 64'(grant), 64'(0));
        chk("ar s_CYC", 64'(s_CYC), 64'(0));
        chk("ar s_STB", 64'(s_STB), 64'(0));
        drive(4'b0101, 4'b0101, 0, 0);
        @(negedge clk);
        #1 chk("ar held", 64'(grant), 64'(0));
        rstn = 1'b1;
        @(negedge clk);
        #1 chk("ar regrant", 64'(grant), 64'(4'b0001));
        drive(4'b0000, 4'b0000, 0, 0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
